fsm_seq_counter: RTL and testbench
==================================

# fsm_seq_counter

Parametrised FSM-controlled sequence counter: the next generation of the lab3 free-running FSM counter, with configurable width, terminal value, prescaled step rate and four run modes (up-wrap, down-wrap, ping-pong, one-shot) plus start/pause/clear control. It sits between board-level control inputs (buttons/switches, already synchronised) and display or pattern logic that consumes `out`, `tc` and `done`.

## Interface
- `WIDTH`, 13: counter width in bits.
- `LIMIT`, 5000: terminal count. Legal range is 1 ≤ LIMIT ≤ 2^WIDTH−1.
- `DIV`, 1: prescale factor; one count step per DIV clocks in RUN. Legal range is DIV ≥ 1.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  synchronous start/restart request.
- `pause`  in  1  level; high freezes a running count.
- `clear`  in  1  synchronous clear to IDLE.
- `mode`  in  2  run mode: 0 up-wrap, 1 down-wrap, 2 ping-pong, 3 one-shot. Sampled only on an accepted `start`.
- `out`  out  WIDTH  current count, registered.
- `tc`  out  1  one-cycle terminal-count pulse, registered.
- `busy`  out  1  high in RUN or HOLD.
- `done`  out  1  high in DONE (mode 3 only).
- `dir`  out  1  1 = counting up, 0 = counting down.

## Operation
- States are IDLE, RUN, HOLD and DONE. The block has an internal latched mode register and a prescaler `pre` that counts 0..DIV−1.
- Input priority each cycle: `clear` > `start` > `pause`.
- `clear` in any state: go to IDLE; out=0, dir=1, pre=0, tc=0.
- `start` in any state, including RUN, HOLD and DONE:
  - Latch `mode`, pre=0, go to RUN.
  - Load out = LIMIT and dir=0 for mode 1; otherwise out=0 and dir=1.
- RUN with `pause`=1: go to HOLD. `out`, `pre` and `dir` freeze.
- HOLD with `pause`=0: return to RUN and resume from the frozen `pre`.
- RUN step: a step occurs when pre==DIV−1; pre then returns to 0. Otherwise pre increments.
- Mode 0 (up-wrap): out+1. A step from LIMIT goes to 0 and raises `tc`.
- Mode 1 (down-wrap): out−1. A step from 0 goes to LIMIT and raises `tc`.
- Mode 2 (ping-pong):
  - Counts up to LIMIT, then down to 0, repeating.
  - `dir` flips on the step that reaches LIMIT or 0.
  - `tc` is raised on the step that reaches LIMIT or 0.
  - With LIMIT=1 the sequence is 0,1,0,1…
- Mode 3 (one-shot): counts up. The step that reaches LIMIT raises `tc` and goes to DONE. `out` holds LIMIT and done=1 until `start` or `clear`.
- `out` never leaves 0..LIMIT. All arithmetic is WIDTH-bit unsigned; no carry escapes.
- IDLE: `out` holds its value, `tc`=0, and `pause` is ignored.

## Timing
- Reset (reset=0, asynchronous) gives: state IDLE, out=0, tc=0, busy=0, done=0, dir=1, pre=0.
- Reset release: the first active edge is the first one with reset=1.
- Accepted `start` at edge k:
  - At edge k, out = initial value and busy=1.
  - The first step lands at edge k+DIV; subsequent steps every DIV edges while in RUN.
- `tc` is registered with the step. It is high exactly during the cycle in which `out` shows the post-step value, and low otherwise.
- `pause` sampled high at edge k: no step at edge k, even if pre==DIV−1.
- `clear` or `start` in the same cycle as a step: the step is discarded and no `tc` is issued.
- `done` rises in the same cycle as the final `tc` and falls at the edge accepting `start` or `clear`.
- `busy` and `done` are mutually exclusive.
- Reset asserted mid-run: all outputs take reset values immediately, without waiting for a clock edge.

## Test plan
- Mode 0, WIDTH=4, LIMIT=5, DIV=1; start pulse:
  - out = 0,1,2,3,4,5,0,1…
  - `tc` high only on the cycle out=0 after 5, once every 6 cycles.
- Mode 1, LIMIT=5, DIV=3:
  - out = 5 held 3 cycles, then 4,3,2,1,0,5, each held 3 cycles.
  - `tc` is one cycle at the 0→5 step.
  - busy=1 throughout.
- Mode 2, LIMIT=3, DIV=1:
  - out = 0,1,2,3,2,1,0,1…
  - dir=0 from out=3 until out=0.
  - `tc` on out=3 and out=0 only.
- Mode 3, LIMIT=4:
  - out = 0..4, then done=1, busy=0, out stays 4 for 20 cycles, `tc` pulses once.
  - A second `start` restarts from 0 with done=0.
- Pause/priority, mode 0, LIMIT=7:
  - Pause 4 cycles at out=3: out stays 3, then continues to 4.
  - `start`+`clear` together: IDLE, out=0.
  - `start`+`pause` together: RUN from 0.
- Async reset (reset=0) mid-run, at out=6 in mode 0 and between clock edges:
  - out=0, tc=0, busy=0, dir=1 immediately.
  - After release, no counting until the next `start`.

Source files
------------

// File: rtl/fsm_seq_counter.sv
// FSM-controlled sequence counter with prescaled stepping and four run modes
// (up-wrap, down-wrap, ping-pong, one-shot) under start/pause/clear control.
module fsm_seq_counter #(
  parameter int WIDTH = 13,
  parameter int LIMIT = 5000,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic             dir
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [WIDTH-1:0] LIM      = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] LIM_M1   = WIDTH'(LIMIT - 1);
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [1:0] M_UP   = 2'd0;
  localparam logic [1:0] M_DOWN = 2'd1;
  localparam logic [1:0] M_PING = 2'd2;
  localparam logic [1:0] M_ONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q,  mode_d;
  logic [PW-1:0]    pre_q,   pre_d;
  logic [WIDTH-1:0] out_q,   out_d;
  logic             dir_q,   dir_d;
  logic             tc_q,    tc_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;

  logic [WIDTH-1:0] step_out_s;
  logic             step_dir_s;
  logic             step_tc_s;
  logic             step_fin_s;

  // Value the counter would take on a step in the latched mode; out-of-range
  // values (only reachable through upset state) are pulled back to LIMIT.
  always_comb begin
    step_out_s = out_q;
    step_dir_s = dir_q;
    step_tc_s  = 1'b0;
    step_fin_s = 1'b0;
    case (mode_q)
      M_UP: begin
        if (out_q >= LIM) begin
          step_out_s = '0;
          step_tc_s  = 1'b1;
        end else begin
          step_out_s = out_q + ONE_W;
        end
      end
      M_DOWN: begin
        if (out_q == '0) begin
          step_out_s = LIM;
          step_tc_s  = 1'b1;
        end else if (out_q > LIM) begin
          step_out_s = LIM;
        end else begin
          step_out_s = out_q - ONE_W;
        end
      end
      M_PING: begin
        if (dir_q) begin
          if (out_q >= LIM_M1) begin
            step_out_s = LIM;
            step_dir_s = 1'b0;
            step_tc_s  = 1'b1;
          end else begin
            step_out_s = out_q + ONE_W;
          end
        end else begin
          if (out_q <= ONE_W) begin
            step_out_s = '0;
            step_dir_s = 1'b1;
            step_tc_s  = 1'b1;
          end else if (out_q > LIM) begin
            step_out_s = LIM;
          end else begin
            step_out_s = out_q - ONE_W;
          end
        end
      end
      M_ONE: begin
        if (out_q >= LIM_M1) begin
          step_out_s = LIM;
          step_tc_s  = 1'b1;
          step_fin_s = 1'b1;
        end else begin
          step_out_s = out_q + ONE_W;
        end
      end
      default: begin
        step_out_s = '0;
      end
    endcase
  end

  // Next-state: clear beats start beats pause; HOLD with pause low steps like RUN.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    out_d   = out_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      out_d   = '0;
      dir_d   = 1'b1;
      pre_d   = '0;
    end else if (start) begin
      state_d = ST_RUN;
      mode_d  = mode;
      pre_d   = '0;
      if (mode == M_DOWN) begin
        out_d = LIM;
        dir_d = 1'b0;
      end else begin
        out_d = '0;
        dir_d = 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_RUN, ST_HOLD: begin
          if (pause) begin
            state_d = ST_HOLD;
          end else if (pre_q >= PRE_LAST) begin
            pre_d   = '0;
            out_d   = step_out_s;
            dir_d   = step_dir_s;
            tc_d    = step_tc_s;
            state_d = step_fin_s ? ST_DONE : ST_RUN;
          end else begin
            pre_d   = pre_q + PRE_ONE;
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: begin
          state_d = ST_IDLE;
          out_d   = '0;
          dir_d   = 1'b1;
          pre_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_HOLD);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= M_UP;
      pre_q   <= '0;
      out_q   <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      out_q   <= out_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign tc   = tc_q;
  assign busy = busy_q;
  assign done = done_q;
  assign dir  = dir_q;

endmodule

// File: tb/tb_fsm_seq_counter.sv
// Scoreboard bench for fsm_seq_counter: five instances with different
// LIMIT/DIV share the control inputs; each scenario observes one of them.
module tb_fsm_seq_counter;

  logic       clk;
  logic       reset;
  logic       start;
  logic       pause;
  logic       clear;
  logic [1:0] mode;

  logic [3:0] out_a [5];
  logic [4:0] tc_a;
  logic [4:0] busy_a;
  logic [4:0] done_a;
  logic [4:0] dir_a;

  int n_checks;
  int n_fails;
  logic [7:0] sb [$];

  fsm_seq_counter #(.WIDTH(4), .LIMIT(5), .DIV(1)) u0 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear), .mode(mode),
    .out(out_a[0]), .tc(tc_a[0]), .busy(busy_a[0]), .done(done_a[0]), .dir(dir_a[0]));
  fsm_seq_counter #(.WIDTH(4), .LIMIT(5), .DIV(3)) u1 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear), .mode(mode),
    .out(out_a[1]), .tc(tc_a[1]), .busy(busy_a[1]), .done(done_a[1]), .dir(dir_a[1]));
  fsm_seq_counter #(.WIDTH(4), .LIMIT(3), .DIV(1)) u2 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear), .mode(mode),
    .out(out_a[2]), .tc(tc_a[2]), .busy(busy_a[2]), .done(done_a[2]), .dir(dir_a[2]));
  fsm_seq_counter #(.WIDTH(4), .LIMIT(4), .DIV(1)) u3 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear), .mode(mode),
    .out(out_a[3]), .tc(tc_a[3]), .busy(busy_a[3]), .done(done_a[3]), .dir(dir_a[3]));
  fsm_seq_counter #(.WIDTH(4), .LIMIT(7), .DIV(1)) u4 (
    .clk(clk), .reset(reset), .start(start), .pause(pause), .clear(clear), .mode(mode),
    .out(out_a[4]), .tc(tc_a[4]), .busy(busy_a[4]), .done(done_a[4]), .dir(dir_a[4]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {out, tc, busy, done, dir}
  function automatic logic [7:0] pk(int o, bit t, bit b, bit d, bit r);
    logic [3:0] o4;
    o4 = 4'(o);
    return {o4, t, b, d, r};
  endfunction

  function automatic logic [7:0] obs(int k);
    return {out_a[k], tc_a[k], busy_a[k], done_a[k], dir_a[k]};
  endfunction

  // Drive inputs from a negedge, let one rising edge consume them, return at next negedge.
  task automatic step(input bit s, input bit p, input bit c, input logic [1:0] m);
    start = s; pause = p; clear = c; mode = m;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; pause = 1'b0; clear = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] got, exp;
    for (int k = 0; k < 5; k++) begin
      sb.push_back(pk(0, 0, 0, 0, 1));
      got = obs(k); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL reset_state inst %0d: got %h expected %h", k, got, exp);
      end
    end
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(pk(0, 0, 0, 0, 1));
      step(0, 1, 0, 2'd0);
      got = obs(0); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL idle_after_release cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mode0_upwrap();
    logic [7:0] got, exp;
    for (int i = 0; i < 15; i++) begin
      sb.push_back(pk(i % 6, (i > 0) && (i % 6 == 0), 1, 0, 1));
      step(i == 0, 0, 0, 2'd0);
      got = obs(0); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL mode0_upwrap cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mode1_downwrap_div3();
    logic [7:0] got, exp;
    int s, o;
    for (int i = 0; i < 24; i++) begin
      s = i / 3;
      o = (((5 - s) % 6) + 6) % 6;
      sb.push_back(pk(o, (i > 0) && (i % 3 == 0) && (o == 5), 1, 0, 0));
      step(i == 0, 0, 0, 2'd1);
      got = obs(1); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL mode1_downwrap cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mode2_pingpong();
    logic [7:0] got, exp;
    int p, o;
    for (int i = 0; i < 14; i++) begin
      p = i % 6;
      o = (p <= 3) ? p : 6 - p;
      sb.push_back(pk(o, (i > 0) && (p == 0 || p == 3), 1, 0, (p >= 3) ? 1'b0 : 1'b1));
      step(i == 0, 0, 0, 2'd2);
      got = obs(2); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL mode2_pingpong cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_mode3_oneshot();
    logic [7:0] got, exp;
    for (int i = 0; i < 27; i++) begin
      if (i < 25) sb.push_back(pk((i < 4) ? i : 4, i == 4, i < 4, i >= 4, 1));
      else        sb.push_back(pk(i - 25, 0, 1, 0, 1));
      step(i == 0 || i == 25, 0, 0, 2'd3);
      got = obs(3); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL mode3_oneshot cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_pause_priority();
    logic [7:0] got, exp;
    int eo [14];
    bit s, p, c;
    eo = '{0, 1, 2, 3, 3, 3, 3, 3, 4, 0, 0, 0, 0, 1};
    for (int i = 0; i < 14; i++) begin
      s = (i == 0) || (i == 9) || (i == 12);
      p = (i >= 4 && i <= 7) || (i == 11) || (i == 12);
      c = (i == 9);
      sb.push_back(pk(eo[i], 0, (i < 9) || (i >= 12), 0, 1));
      step(s, p, c, 2'd0);
      got = obs(4); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL pause_priority cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got, exp;
    logic [1:0] m;
    for (int i = 0; i < 10; i++) begin
      if (i <= 5)      sb.push_back(pk(i, 0, 1, 0, 1));
      else if (i == 6) sb.push_back(pk(0, 0, 1, 0, 1));
      else if (i == 7) sb.push_back(pk(1, 0, 1, 0, 1));
      else if (i == 8) sb.push_back(pk(5, 0, 1, 0, 0));
      else             sb.push_back(pk(4, 0, 1, 0, 0));
      m = (i == 8) ? 2'd1 : 2'd0;
      step(i == 0 || i == 6 || i == 8, 0, 0, m);
      got = obs(0); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] got, exp;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(pk(i, 0, 1, 0, 1));
      step(i == 0, 0, 0, 2'd0);
      got = obs(4); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL reset_prerun cyc %0d: got %h expected %h", i, got, exp);
      end
    end
    #2 reset = 1'b0;
    #1;
    sb.push_back(pk(0, 0, 0, 0, 1));
    got = obs(4); exp = sb.pop_front(); n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL async_reset_immediate: got %h expected %h", got, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(pk(0, 0, 0, 0, 1));
      step(0, 0, 0, 2'd0);
      got = obs(4); exp = sb.pop_front(); n_checks++;
      if (got !== exp) begin
        n_fails++;
        $display("FAIL reset_no_count cyc %0d: got %h expected %h", i, got, exp);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    reset = 1'b0;
    start = 1'b0; pause = 1'b0; clear = 1'b0; mode = 2'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mode0_upwrap();
    test_mode1_downwrap_div3();
    test_mode2_pingpong();
    test_mode3_oneshot();
    test_pause_priority();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
